// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and default parameters for the PC / instruction-fetch sequencer.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam int          DEF_ADDR_W     = 32;
  localparam int          DEF_DATA_W     = 32;
  localparam logic [31:0] DEF_RESET_ADDR = 32'h0000_0000;
  localparam int          DEF_PC_INC     = 4;

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Architectural PC register with load enable, plus the pc + increment adder
// whose result goes back to the branch-select mux.
module pc_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR),
  parameter int                PC_INC     = DEF_PC_INC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] next_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_add
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_ADDR;
    end else if (load) begin
      pc <= next_addr;
    end
  end

  // Wraps modulo 2^ADDR_W with no overflow indication.
  assign pc_add = pc + ADDR_W'(PC_INC);

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch sequencer: requests the instruction at pc, holds it for decode, and
// loads next_addr into pc when decode consumes it.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(DEF_RESET_ADDR),
  parameter int                PC_INC     = DEF_PC_INC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] next_addr,
  output logic [ADDR_W-1:0] pc_add,
  output logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              stall,
  input  logic              halt,
  output logic              halted
);

  state_t state, state_next;
  logic   consume;

  assign consume = (state == VALID) && instr_ready && !stall;

  pc_reg #(
    .ADDR_W    (ADDR_W),
    .RESET_ADDR(RESET_ADDR),
    .PC_INC    (PC_INC)
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (consume),
    .next_addr(next_addr),
    .pc       (pc),
    .pc_add   (pc_add)
  );

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = REQ;
      REQ:     if (imem_ack) state_next = VALID;
      VALID:   if (consume) state_next = halt ? HALT : REQ;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset drops them at once.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      REQ:     imem_req    = 1'b1;
      VALID:   instr_valid = 1'b1;
      HALT:    halted      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr <= '0;
    end else if ((state == REQ) && imem_ack) begin
      instr <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench: directed scenarios plus randomized traffic, all checked
// each cycle against a transaction-level model of the fetch sequencer.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] next_addr;
  logic [31:0] pc_add;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        halt;
  logic        halted;

  int compared;
  int mismatched;

  // Model: what the unit is doing, in plain words.
  localparam int M_QUIET   = 0;
  localparam int M_FETCH   = 1;
  localparam int M_PRESENT = 2;
  localparam int M_STOPPED = 3;
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  pc_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .next_addr  (next_addr),
    .pc_add     (pc_add),
    .pc         (pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .stall      (stall),
    .halt       (halt),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h required %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_QUIET;
    m_pc    = 32'h0;
    m_instr = 32'h0;
  endtask

  task automatic check_against_model();
    checkOutput("pc", pc, m_pc);
    checkOutput("pc_add", pc_add, m_pc + 32'd4);
    checkOutput("imem_addr", imem_addr, m_pc);
    checkOutput("imem_req", {31'd0, imem_req}, {31'd0, m_phase == M_FETCH});
    checkOutput("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == M_PRESENT});
    checkOutput("instr", instr, m_instr);
    checkOutput("halted", {31'd0, halted}, {31'd0, m_phase == M_STOPPED});
  endtask

  // Called at a falling edge: check, drive, advance model, move to next falling edge.
  task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic ready,
                               input logic st, input logic hl, input logic [31:0] naddr);
    check_against_model();
    imem_ack    = ack;
    imem_rdata  = rdata;
    instr_ready = ready;
    stall       = st;
    halt        = hl;
    next_addr   = naddr;
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_phase)
        M_QUIET: m_phase = M_FETCH;
        M_FETCH: if (ack) begin
          m_instr = rdata;
          m_phase = M_PRESENT;
        end
        M_PRESENT: if (ready && !st) begin
          m_pc    = naddr;
          m_phase = hl ? M_STOPPED : M_FETCH;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_and_release();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] held_instr;

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    stall       = 1'b0;
    halt        = 1'b0;
    next_addr   = 32'h0;
    model_reset();

    // Reset values.
    @(negedge clk);
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First fetch: one quiet cycle, then request at 0, ack one cycle late.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4);
    checkOutput("first_req", {31'd0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);
    checkOutput("first_pc_add", pc_add, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h4);
    checkOutput("ack_wait_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b1, 32'hA000_0000, 1'b1, 1'b0, 1'b0, 32'h4);
    checkOutput("first_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("first_instr", instr, 32'hA000_0000);

    // Sequential run with next_addr = pc + 4.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4);
      checkOutput("seq_addr", imem_addr, 32'(4 * i));
      applyStimulus(1'b1, 32'hA000_0000 + 32'(i), 1'b1, 1'b0, 1'b0, 32'h0);
    end

    // Branch to 0x100.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h100);
    checkOutput("branch_addr", imem_addr, 32'h100);
    checkOutput("branch_pc_add", pc_add, 32'h104);
    applyStimulus(1'b1, 32'hB0B0_0100, 1'b1, 1'b0, 1'b0, 32'h0);

    // Backpressure: stall or not-ready for 5 cycles, halt during stall ignored.
    held_instr = instr;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'hDEAD_0000, (i % 2) == 0, (i % 2) == 0, i == 2, 32'h5555_0000);
      checkOutput("bp_instr", instr, held_instr);
      checkOutput("bp_pc", pc, 32'h100);
      checkOutput("bp_req", {31'd0, imem_req}, 32'd0);
      checkOutput("bp_halted", {31'd0, halted}, 32'd0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h104);
    checkOutput("bp_release_pc", pc, 32'h104);
    checkOutput("bp_release_req", {31'd0, imem_req}, 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h999);
    checkOutput("bp_single_consume", pc, 32'h104);

    // Wrap at the top of the address space.
    applyStimulus(1'b1, 32'hC0DE_0104, 1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc_add", pc_add, 32'h0);
    applyStimulus(1'b1, 32'hC0DE_FFFC, 1'b1, 1'b0, 1'b0, 32'h0);

    // Halt on a consume, sticky afterwards.
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h20);
    checkOutput("halt_halted", {31'd0, halted}, 32'd1);
    checkOutput("halt_pc", pc, 32'h20);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h40);
      checkOutput("halt_req", {31'd0, imem_req}, 32'd0);
      checkOutput("halt_sticky_pc", pc, 32'h20);
    end

    // Reset mid-REQ: request drops immediately, late ack ignored.
    reset_and_release();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("midreq_req_before", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreq_req_drop", {31'd0, imem_req}, 32'd0);
    checkOutput("midreq_valid_drop", {31'd0, instr_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    applyStimulus(1'b1, 32'hBAD0_0001, 1'b1, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'hBAD0_0002, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("late_ack_instr", instr, 32'h0);
    checkOutput("late_ack_valid", {31'd0, instr_valid}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Randomized traffic in bursts, each starting from reset.
    for (int burst = 0; burst < 6; burst++) begin
      reset_and_release();
      for (int cyc = 0; cyc < 150; cyc++) begin
        applyStimulus($urandom_range(0, 2) != 0, $urandom,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 59) == 0,
                      ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4);
      end
    end
    check_against_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
